ff_prbs_checker: RTL and testbench

FF_PRBS_CHECKER -- requirements
Module: ff_prbs_checker

---
 rtl/ff_pkg.sv | 17 +
 rtl/prbs7_step.sv | 18 +
 rtl/ff_prbs_checker.sv | 127 ++++++++++++
 tb/tb_ff_prbs_checker.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/ff_pkg.sv
// Shared types and constants for the PRBS-7 checker and its generator twin.
package ff_pkg;

  typedef enum logic [1:0] {
    StHunt = 2'd0,
    StSync = 2'd1,
    StLock = 2'd2
  } ff_state_e;

  // x^7 + x^6 + 1: feedback from s[6] and s[5]
  localparam logic [6:0] Prbs7Taps = 7'b110_0000;

  localparam int unsigned DefSyncLen = 16;
  localparam int unsigned DefLossErr = 8;
  localparam int unsigned DefLossWin = 64;

endpackage

// File: rtl/prbs7_step.sv
// Combinational PRBS-7 step: predicted bit and next shift-register value.
// With load_in=0 it free-runs, which is how the ff_data_sink generator uses it.
module prbs7_step
  import ff_pkg::*;
(
  input  logic [6:0] s,
  input  logic       in_bit,
  input  logic       load_in,
  output logic       predict,
  output logic [6:0] s_next
);

  always_comb begin
    predict = ^(s & Prbs7Taps);
    s_next  = {s[5:0], (load_in ? in_bit : predict)};
  end

endmodule

// File: rtl/ff_prbs_checker.sv
// PRBS-7 receive checker: hunts for alignment, confirms over SYNC_LEN bits,
// then counts bit errors against a free-running local generator.
module ff_prbs_checker
  import ff_pkg::*;
#(
  parameter int unsigned SYNC_LEN = DefSyncLen,
  parameter int unsigned LOSS_ERR = DefLossErr,
  parameter int unsigned LOSS_WIN = DefLossWin
) (
  input  logic        ff_clk,
  input  logic        reset,
  input  logic        ff_en,
  input  logic        ff_data,
  input  logic        clear,
  output logic        locked,
  output logic        err_pulse,
  output logic [15:0] err_cnt,
  output logic [31:0] bit_cnt
);

  localparam int unsigned MatchW = $clog2(SYNC_LEN + 1);
  localparam int unsigned WinW   = (LOSS_WIN > 1) ? $clog2(LOSS_WIN) : 1;
  localparam int unsigned ErrW   = $clog2(LOSS_ERR + 1);

  ff_state_e         state_q;
  logic [6:0]        s_q;
  logic [2:0]        fill_q;
  logic [MatchW-1:0] match_q;
  logic [WinW-1:0]   win_q;
  logic [ErrW-1:0]   win_err_q;

  logic       predict;
  logic [6:0] s_next;
  logic       mismatch;
  logic       lose_lock;

  // Outside LOCK the register tracks the line; in LOCK it free-runs so one
  // corrupted bit is counted once instead of poisoning the next seven predictions.
  prbs7_step u_step (
    .s       (s_q),
    .in_bit  (ff_data),
    .load_in (state_q != StLock),
    .predict (predict),
    .s_next  (s_next)
  );

  always_comb begin
    mismatch  = ff_data ^ predict;
    lose_lock = (s_q == 7'd0) ||
                (mismatch && (win_err_q == ErrW'(LOSS_ERR - 1)));
  end

  always_ff @(posedge ff_clk) begin
    if (reset) begin
      state_q   <= StHunt;
      s_q       <= 7'd0;
      fill_q    <= 3'd0;
      match_q   <= '0;
      win_q     <= '0;
      win_err_q <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= 16'd0;
      bit_cnt   <= 32'd0;
    end else begin
      err_pulse <= 1'b0;
      if (ff_en) begin
        s_q <= s_next;
        unique case (state_q)
          StHunt: begin
            if (fill_q == 3'd6) begin
              fill_q  <= 3'd0;
              match_q <= '0;
              state_q <= StSync;
            end else begin
              fill_q <= fill_q + 3'd1;
            end
          end
          StSync: begin
            if (mismatch) begin
              fill_q  <= 3'd0;
              state_q <= StHunt;
            end else if (match_q == MatchW'(SYNC_LEN - 1)) begin
              win_q     <= '0;
              win_err_q <= '0;
              state_q   <= StLock;
              locked    <= 1'b1;
            end else begin
              match_q <= match_q + MatchW'(1);
            end
          end
          StLock: begin
            if (bit_cnt != 32'hFFFF_FFFF) bit_cnt <= bit_cnt + 32'd1;
            if (mismatch) begin
              err_pulse <= 1'b1;
              if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            end
            if (lose_lock) begin
              fill_q    <= 3'd0;
              match_q   <= '0;
              win_q     <= '0;
              win_err_q <= '0;
              state_q   <= StHunt;
              locked    <= 1'b0;
            end else if (win_q == WinW'(LOSS_WIN - 1)) begin
              win_q     <= '0;
              win_err_q <= '0;
            end else begin
              win_q     <= win_q + WinW'(1);
              win_err_q <= win_err_q + ErrW'(mismatch);
            end
          end
          default: begin
            state_q <= StHunt;
            locked  <= 1'b0;
          end
        endcase
      end
      // Clear beats any increment made above in the same cycle.
      if (clear) begin
        err_cnt <= 16'd0;
        bit_cnt <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_ff_prbs_checker.sv
// Directed bench for ff_prbs_checker: scenario table plus hand-written edge cases.
module tb_ff_prbs_checker;

  logic        ff_clk = 1'b0;
  logic        reset;
  logic        ff_en;
  logic        ff_data;
  logic        clear;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_cnt;
  logic [31:0] bit_cnt;

  always #5 ff_clk = ~ff_clk;

  ff_prbs_checker dut (
    .ff_clk    (ff_clk),
    .reset     (reset),
    .ff_en     (ff_en),
    .ff_data   (ff_data),
    .clear     (clear),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt),
    .bit_cnt   (bit_cnt)
  );

  typedef struct {
    string name;
    bit    rst;
    int    nbits;
    int    period;
    bit    flip;
    bit    exp_locked;
    int    exp_err;
    int    exp_bits;
  } row_t;

  row_t       rows[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [6:0] gen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input string name, input bit rst, input int nbits, input int period,
                     input bit flip, input bit exp_locked, input int exp_err, input int exp_bits);
    row_t r;
    r.name = name; r.rst = rst; r.nbits = nbits; r.period = period; r.flip = flip;
    r.exp_locked = exp_locked; r.exp_err = exp_err; r.exp_bits = exp_bits;
    rows.push_back(r);
  endtask

  // Reference PRBS-7 source, x^7+x^6+1, independent of the DUT.
  task automatic gen_bit(output logic b);
    b   = gen[6] ^ gen[5];
    gen = {gen[5:0], b};
  endtask

  task automatic step(input logic en, input logic d, input logic c);
    ff_en   = en;
    ff_data = d;
    clear   = c;
    @(posedge ff_clk);
    #1;
    ff_en = 1'b0;
    clear = 1'b0;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    ff_en   = 1'b1;
    ff_data = 1'b1;
    clear   = 1'b0;
    @(posedge ff_clk);
    #1;
    reset = 1'b0;
    ff_en = 1'b0;
    gen   = 7'h7F;
  endtask

  // period=3 gives two idle cycles with junk data before each enabled bit.
  task automatic send_bits(input int n, input int period, input bit flip);
    logic b;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < period - 1; k++) step(1'b0, 1'($urandom), 1'b0);
      gen_bit(b);
      step(1'b1, b ^ flip, 1'b0);
    end
  endtask

  initial begin
    logic b;
    reset   = 1'b1;
    ff_en   = 1'b0;
    ff_data = 1'b0;
    clear   = 1'b0;
    gen     = 7'h7F;

    do_reset();
    chk("reset_locked", 32'(locked), 32'd0);
    chk("reset_pulse", 32'(err_pulse), 32'd0);
    chk("reset_err_cnt", 32'(err_cnt), 32'd0);
    chk("reset_bit_cnt", bit_cnt, 32'd0);

    //   name            rst  n   per flip lock err bits
    add("pre_lock",      1, 22,  1, 0,   0,   0,  0);
    add("lock_at_23",    0,  1,  1, 0,   1,   0,  0);
    add("locked_clean",  0, 10,  1, 0,   1,   0, 10);
    add("single_err",    0,  1,  1, 1,   1,   1, 11);
    add("after_err",     0,  5,  1, 0,   1,   1, 16);
    add("burst_loss",    0,  7,  1, 1,   0,   8, 23);
    add("relock_pre",    0, 22,  1, 0,   0,   8, 23);
    add("relock",        0,  1,  1, 0,   1,   8, 23);
    add("en3_pre_lock",  1, 22,  3, 0,   0,   0,  0);
    add("en3_lock",      0,  1,  3, 0,   1,   0,  0);
    add("en3_bits",      0,  9,  3, 0,   1,   0,  9);
    add("sync_pre",      1, 16,  1, 0,   0,   0,  0);
    add("sync_err",      0,  1,  1, 1,   0,   0,  0);
    add("sync_restart",  0, 22,  1, 0,   0,   0,  0);
    add("sync_relock",   0,  1,  1, 0,   1,   0,  0);
    add("win_lock",      1, 23,  1, 0,   1,   0,  0);
    add("win_7err",      0,  7,  1, 1,   1,   7,  7);
    add("win_wrap",      0, 57,  1, 0,   1,   7, 64);
    add("win_7err_b",    0,  7,  1, 1,   1,  14, 71);
    add("win_8th_err",   0,  1,  1, 1,   0,  15, 72);

    foreach (rows[i]) begin
      if (rows[i].rst) do_reset();
      send_bits(rows[i].nbits, rows[i].period, rows[i].flip);
      chk({rows[i].name, ".locked"}, 32'(locked), 32'(rows[i].exp_locked));
      chk({rows[i].name, ".err_cnt"}, 32'(err_cnt), 32'(rows[i].exp_err));
      chk({rows[i].name, ".bit_cnt"}, bit_cnt, 32'(rows[i].exp_bits));
    end

    // err_pulse latency and idle-cycle behaviour
    do_reset();
    send_bits(23, 1, 1'b0);
    chk("hs_locked", 32'(locked), 32'd1);
    chk("hs_pulse_before", 32'(err_pulse), 32'd0);
    gen_bit(b);
    step(1'b1, ~b, 1'b0);
    chk("hs_pulse", 32'(err_pulse), 32'd1);
    chk("hs_err_cnt", 32'(err_cnt), 32'd1);
    chk("hs_still_locked", 32'(locked), 32'd1);
    gen_bit(b);
    step(1'b1, b, 1'b0);
    chk("hs_pulse_one_cycle", 32'(err_pulse), 32'd0);
    repeat (4) step(1'b0, 1'($urandom), 1'b0);
    chk("hs_idle_bit_cnt", bit_cnt, 32'd2);
    chk("hs_idle_pulse", 32'(err_pulse), 32'd0);

    // clear coinciding with an error
    gen_bit(b);
    step(1'b1, ~b, 1'b1);
    chk("clr_err_cnt", 32'(err_cnt), 32'd0);
    chk("clr_bit_cnt", bit_cnt, 32'd0);
    chk("clr_pulse", 32'(err_pulse), 32'd1);
    chk("clr_locked", 32'(locked), 32'd1);
    gen_bit(b);
    step(1'b1, ~b, 1'b0);
    chk("post_clr_err_cnt", 32'(err_cnt), 32'd1);

    // reset mid-LOCK with enable, error and no clear
    gen_bit(b);
    reset   = 1'b1;
    ff_en   = 1'b1;
    ff_data = ~b;
    clear   = 1'b0;
    @(posedge ff_clk);
    #1;
    reset = 1'b0;
    ff_en = 1'b0;
    chk("mid_rst_locked", 32'(locked), 32'd0);
    chk("mid_rst_pulse", 32'(err_pulse), 32'd0);
    chk("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("mid_rst_bit_cnt", bit_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
